// File: rtl/reflet_vga_scanout_if.sv
// Framebuffer read port and video output bundle for the VGA scanout engine.
// The master side is the scanout; the slave side is the RAM plus video sink.
interface reflet_vga_scanout_if #(
    parameter int addrSize = 16,
    parameter int depth    = 8
);
    logic [addrSize-1:0] addr_read;
    logic                ram_enable;
    logic [depth-1:0]    data_out;
    logic [depth-1:0]    pixel;
    logic                hsync;
    logic                vsync;
    logic                active;
    logic                frame_start;

    modport master (
        output addr_read, ram_enable, pixel, hsync, vsync, active, frame_start,
        input  data_out
    );

    modport slave (
        input  addr_read, ram_enable, pixel, hsync, vsync, active, frame_start,
        output data_out
    );
endinterface

// File: rtl/reflet_vga_scanout.sv
// VGA timing generator with linear framebuffer addressing. Sync/active outputs are
// registered one clk behind the counters so they line up with the 1-clk RAM read.
module reflet_vga_scanout #(
    parameter int   addrSize = 16,
    parameter int   depth    = 8,
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter int   CLK_DIV  = 4,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    reflet_vga_scanout_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0]       div_q, div_d;
    logic [HW-1:0]       h_q, h_d;
    logic [VW-1:0]       v_q, v_d;
    logic [addrSize-1:0] lin_addr_q, lin_addr_d;
    logic                active_q, hsync_q, vsync_q, frame_start_q;

    logic tick, h_end, v_end, vis, hs_raw, vs_raw;

    // With CLK_DIV=1 the divider is stuck at 0 and tick is permanently high.
    assign tick  = (div_q == DW'(CLK_DIV - 1));
    assign h_end = (h_q == HW'(H_TOTAL - 1));
    assign v_end = (v_q == VW'(V_TOTAL - 1));
    assign vis   = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));

    assign hs_raw = (h_q >= HW'(H_ACTIVE + H_FP)) &&
                    (h_q <= HW'(H_ACTIVE + H_FP + H_SYNC - 1));
    assign vs_raw = (v_q >= VW'(V_ACTIVE + V_FP)) &&
                    (v_q <= VW'(V_ACTIVE + V_FP + V_SYNC - 1));

    always_comb begin
        div_d      = div_q;
        h_d        = h_q;
        v_d        = v_q;
        lin_addr_d = lin_addr_q;
        if (enable) begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick) begin
                if (h_end) begin
                    h_d = '0;
                    v_d = v_end ? '0 : v_q + 1'b1;
                end else begin
                    h_d = h_q + 1'b1;
                end
                // Frame wrap is never visible, so the two branches cannot collide.
                if (h_end && v_end) begin
                    lin_addr_d = '0;
                end else if (vis) begin
                    lin_addr_d = lin_addr_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q         <= '0;
            h_q           <= '0;
            v_q           <= '0;
            lin_addr_q    <= '0;
            active_q      <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            lin_addr_q    <= lin_addr_d;
            active_q      <= vis && enable;
            hsync_q       <= hs_raw ? SYNC_POL : ~SYNC_POL;
            vsync_q       <= vs_raw ? SYNC_POL : ~SYNC_POL;
            frame_start_q <= (h_q == '0) && (v_q == '0) && (div_q == '0) && enable;
        end
    end

    assign bus.addr_read   = lin_addr_q;
    assign bus.ram_enable  = vis && enable;
    assign bus.pixel       = active_q ? bus.data_out : '0;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.active      = active_q;
    assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_reflet_vga_scanout.sv
// Scoreboard bench for two scanout instances (CLK_DIV=1 and CLK_DIV=4) sharing
// enable/reset; expectations come from a raster-position model of the video timing.
module tb_reflet_vga_scanout;
    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic [7:0] pixel;
        logic       active;
        logic       hsync;
        logic       vsync;
        logic       fs;
        logic       ram_en;
        logic [7:0] addr;
    } exp_t;

    typedef struct packed {
        exp_t e1;
        exp_t e4;
    } rec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   cnt = 0;
    rec_t q[$];

    reflet_vga_scanout_if #(.addrSize(4), .depth(8)) if1 ();
    reflet_vga_scanout_if #(.addrSize(4), .depth(8)) if4 ();

    reflet_vga_scanout #(
        .addrSize(4), .depth(8), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CLK_DIV(1), .SYNC_POL(1'b0)
    ) u_dut1 (.clk(clk), .reset(reset), .enable(enable), .bus(if1));

    reflet_vga_scanout #(
        .addrSize(4), .depth(8), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CLK_DIV(4), .SYNC_POL(1'b0)
    ) u_dut4 (.clk(clk), .reset(reset), .enable(enable), .bus(if4));

    always #5 clk = ~clk;

    // Framebuffer RAMs: word at address a holds a + 0x10, one clk read latency.
    always @(posedge clk) begin
        if (if1.ram_enable) if1.data_out <= {4'h0, if1.addr_read} + 8'h10;
        if (if4.ram_enable) if4.data_out <= {4'h0, if4.addr_read} + 8'h10;
    end

    function automatic bit vis_of(int pos);
        return ((pos % HT) < HA) && ((pos / HT) < VA);
    endfunction

    // Number of visible pixels already scanned in the frame before raster position pos.
    function automatic int addr_of(int pos);
        int h, v;
        h = pos % HT;
        v = pos / HT;
        if (v >= VA) return HA * VA;
        return v * HA + ((h < HA) ? h : HA);
    endfunction

    // cnt = enabled clocks since reset, taken just before the clock edge.
    function automatic exp_t model(int c, bit en, int cd);
        exp_t e;
        int pos, pos2, h, v;
        pos  = (c / cd) % FRAME;
        pos2 = ((c + (en ? 1 : 0)) / cd) % FRAME;
        h    = pos % HT;
        v    = pos / HT;
        e.active = en && vis_of(pos);
        e.hsync  = !((h >= HA + HF) && (h < HA + HF + HS));
        e.vsync  = !((v >= VA + VF) && (v < VA + VF + VS));
        e.fs     = en && (pos == 0) && ((c % cd) == 0);
        e.pixel  = e.active ? 8'(16 + addr_of(pos)) : 8'h00;
        e.addr   = 8'(addr_of(pos2));
        e.ram_en = en && vis_of(pos2);
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(string tag, exp_t e, logic [7:0] pix, logic act, logic hs,
                           logic vs, logic fs, logic re, logic [3:0] addr);
        chk({tag, ".pixel"}, {24'h0, pix}, {24'h0, e.pixel});
        chk({tag, ".active"}, {31'h0, act}, {31'h0, e.active});
        chk({tag, ".hsync"}, {31'h0, hs}, {31'h0, e.hsync});
        chk({tag, ".vsync"}, {31'h0, vs}, {31'h0, e.vsync});
        chk({tag, ".frame_start"}, {31'h0, fs}, {31'h0, e.fs});
        chk({tag, ".ram_enable"}, {31'h0, re}, {31'h0, e.ram_en});
        chk({tag, ".addr_read"}, {28'h0, addr}, {24'h0, e.addr});
    endtask

    task automatic chk_reset_state(string tag);
        chk({tag, ".dut1.pixel"}, {24'h0, if1.pixel}, 32'h0);
        chk({tag, ".dut1.active"}, {31'h0, if1.active}, 32'h0);
        chk({tag, ".dut1.frame_start"}, {31'h0, if1.frame_start}, 32'h0);
        chk({tag, ".dut1.hsync"}, {31'h0, if1.hsync}, 32'h1);
        chk({tag, ".dut1.vsync"}, {31'h0, if1.vsync}, 32'h1);
        chk({tag, ".dut1.addr_read"}, {28'h0, if1.addr_read}, 32'h0);
        chk({tag, ".dut4.pixel"}, {24'h0, if4.pixel}, 32'h0);
        chk({tag, ".dut4.active"}, {31'h0, if4.active}, 32'h0);
        chk({tag, ".dut4.hsync"}, {31'h0, if4.hsync}, 32'h1);
        chk({tag, ".dut4.vsync"}, {31'h0, if4.vsync}, 32'h1);
        chk({tag, ".dut4.addr_read"}, {28'h0, if4.addr_read}, 32'h0);
    endtask

    task automatic step(bit en);
        rec_t r;
        @(negedge clk);
        enable = en;
        r.e1 = model(cnt, en, 1);
        r.e4 = model(cnt, en, 4);
        q.push_back(r);
        cnt += en ? 1 : 0;
    endtask

    // Monitor: every expected record is consumed just after the edge it describes.
    initial begin
        rec_t r;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                r = q.pop_front();
                cmp_dut("dut1", r.e1, if1.pixel, if1.active, if1.hsync, if1.vsync,
                        if1.frame_start, if1.ram_enable, if1.addr_read);
                cmp_dut("dut4", r.e4, if4.pixel, if4.active, if4.hsync, if4.vsync,
                        if4.frame_start, if4.ram_enable, if4.addr_read);
            end
        end
    end

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_state("reset_initial");
        reset = 1'b0;
        cnt   = 0;

        repeat (60) step(1'b1);

        // Pause mid-line at h=2 of a visible line.
        while (!(((cnt % FRAME) % HT) == 2 && ((cnt % FRAME) / HT) < VA)) step(1'b1);
        repeat (5) step(1'b0);
        repeat (10) step(1'b1);

        for (int i = 0; i < 300; i++) step($urandom_range(0, 3) != 0);

        // Async reset landing at h=3, v=1 of the CLK_DIV=1 instance.
        while ((cnt % FRAME) != HT + 3) step(1'b1);
        @(negedge clk);
        #2;
        enable = 1'b0;
        reset  = 1'b1;
        #1;
        chk_reset_state("reset_async");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        cnt   = 0;

        repeat (250) step(1'b1);
        for (int i = 0; i < 200; i++) step($urandom_range(0, 4) != 0);

        @(negedge clk);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        chk("scoreboard_drain", q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
